// File: rtl/lustre_delay_if.sv
// Stream bundle for the Lustre delay operator: control, sample/init data and delayed result.
// The primed flag is only carried when LUSTRE_DELAY_PRIMED_EN is defined.
interface lustre_delay_if #(
    parameter int N = 1
);
    logic         init;
    logic         enable;
    logic [N-1:0] init_val;
    logic [N-1:0] next_val;
    logic [N-1:0] res;
`ifdef LUSTRE_DELAY_PRIMED_EN
    logic         primed;

    modport master (
        output init, enable, init_val, next_val,
        input  res, primed
    );

    modport slave (
        input  init, enable, init_val, next_val,
        output res, primed
    );
`else
    modport master (
        output init, enable, init_val, next_val,
        input  res
    );

    modport slave (
        input  init, enable, init_val, next_val,
        output res
    );
`endif
endinterface

// File: rtl/lustre_delay.sv
// Lustre delay operator: init_val -> pre^DEPTH(next_val), advancing only on active ticks.
// Optional primed output enabled by defining LUSTRE_DELAY_PRIMED_EN.
module lustre_delay #(
    parameter int N     = 1,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    lustre_delay_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  stage [DEPTH];
    logic [CW-1:0] cnt;
    logic          full;
    logic          show;

    assign full = (cnt == CW'(DEPTH));
    // init overrides the output in its own cycle, regardless of fill state.
    assign show = !bus.init && full;

    // NOTE: the shift register is reset along with the counter so res never
    // carries X after reset, even though the counter already masks stale data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (bus.enable) begin
            stage[0] <= bus.next_val;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Fill counter saturates at DEPTH; an init on an active tick counts that tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (bus.enable) begin
            if (bus.init) begin
                cnt <= CW'(1);
            end else if (!full) begin
                cnt <= cnt + CW'(1);
            end
        end else if (bus.init) begin
            cnt <= '0;
        end
    end

    assign bus.res = show ? stage[DEPTH-1] : bus.init_val;

`ifdef LUSTRE_DELAY_PRIMED_EN
    assign bus.primed = show;
`endif

endmodule

// File: tb/tb_lustre_delay.sv
// Self-checking bench for lustre_delay (N=8, DEPTH=3): directed table, reset cases
// and randomized traffic compared against a queue-based stream model.
module tb_lustre_delay;
    localparam int N     = 8;
    localparam int DEPTH = 3;

    logic clock;
    logic reset_n;

    lustre_delay_if #(.N(N)) bus ();

    lustre_delay #(.N(N), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Stream model: history of sampled values plus number of active samples
    // taken since the last restart of the fill.
    logic [N-1:0] hist[$];
    int           fill = 0;

    typedef struct {
        logic         init;
        logic         enable;
        logic [N-1:0] init_val;
        logic [N-1:0] next_val;
        logic [N-1:0] exp_res;
        logic         exp_primed;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_primed(input string name, input logic expected);
`ifdef LUSTRE_DELAY_PRIMED_EN
        checks++;
        if (bus.primed !== expected) begin
            errors++;
            $display("FAIL %s: primed got %b expected %b at %0t", name, bus.primed, expected, $time);
        end
`endif
    endtask

    function automatic logic model_primed();
        return !bus.init && fill >= DEPTH;
    endfunction

    function automatic logic [N-1:0] model_res();
        return model_primed() ? hist[hist.size() - DEPTH] : bus.init_val;
    endfunction

    // Apply inputs half a cycle ahead of the edge, then settle before sampling.
    task automatic drive(input logic i, input logic e, input logic [N-1:0] iv, input logic [N-1:0] nv);
        @(negedge clock);
        bus.init     = i;
        bus.enable   = e;
        bus.init_val = iv;
        bus.next_val = nv;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset_n) begin
            fill = 0;
        end else if (bus.enable) begin
            hist.push_back(bus.next_val);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            fill = bus.init ? 1 : fill + 1;
        end else if (bus.init) begin
            fill = 0;
        end
    endtask

    initial begin
        logic [N-1:0] iv;
        logic [N-1:0] first;

        vecs = '{
            // fill
            '{1'b1, 1'b1, 8'h55, 8'h01, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h02, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h03, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h04, 8'h01, 1'b1},
            '{1'b0, 1'b1, 8'h55, 8'h05, 8'h02, 1'b1},
            // gaps: one inactive cycle between ticks 1 and 2
            '{1'b1, 1'b1, 8'h55, 8'h01, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h02, 8'h55, 1'b0},
            '{1'b0, 1'b0, 8'h55, 8'hEE, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h03, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h04, 8'h01, 1'b1},
            '{1'b0, 1'b1, 8'h55, 8'h05, 8'h02, 1'b1},
            '{1'b0, 1'b0, 8'h55, 8'hEE, 8'h03, 1'b1},
            '{1'b0, 1'b0, 8'h55, 8'hEE, 8'h03, 1'b1},
            // init mid-stream
            '{1'b1, 1'b1, 8'h55, 8'h10, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h11, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h12, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h13, 8'h10, 1'b1},
            // init while inactive, with an init_val change during the fill
            '{1'b1, 1'b0, 8'h55, 8'hEE, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h20, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'hA5, 8'h21, 8'hA5, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h22, 8'h55, 1'b0},
            '{1'b0, 1'b1, 8'h55, 8'h23, 8'h20, 1'b1}
        };

        reset_n      = 1'b0;
        bus.init     = 1'b0;
        bus.enable   = 1'b1;
        bus.init_val = 8'h55;
        bus.next_val = 8'h00;

        // Reset held with toggling data.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 8'h55, (k % 2) ? 8'hFF : 8'h00);
            check("reset_res", bus.res, 8'h55);
            check_primed("reset_primed", 1'b0);
            tick();
        end
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[r]) begin
            drive(vecs[r].init, vecs[r].enable, vecs[r].init_val, vecs[r].next_val);
            check($sformatf("vec%0d_res", r), bus.res, vecs[r].exp_res);
            check_primed($sformatf("vec%0d_primed", r), vecs[r].exp_primed);
            tick();
        end

        // Async reset mid-run: asserted between edges, visible before the next edge.
        drive(1'b0, 1'b1, 8'h55, 8'h30);
        check("pre_reset_res", bus.res, model_res());
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_res", bus.res, 8'h55);
        check_primed("async_reset_primed", 1'b0);
        fill = 0;
        drive(1'b0, 1'b1, 8'h55, 8'h31);
        check("reset_held_res", bus.res, 8'h55);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 8'h55, 8'h40 + 8'(k));
            if (k == 0) reset_n = 1'b1;
            check($sformatf("post_reset%0d_res", k), bus.res, (k < 3) ? 8'h55 : 8'h40);
            check_primed($sformatf("post_reset%0d_primed", k), k == 3);
            tick();
        end

        // Randomized traffic against the stream model.
        for (int k = 0; k < 400; k++) begin
            iv = 8'($urandom);
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), iv, 8'($urandom));
            first = model_res();
            check($sformatf("rand%0d_res", k), bus.res, first);
            check_primed($sformatf("rand%0d_primed", k), model_primed());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
